// File: rtl/crack_scheduler.sv
// rtl/crack_scheduler.sv - round-robin chunk dispatcher and hit latch for a multi-engine DES key search (optional feature macro: CRACK_SCHED_LIMIT_EN)
module crack_scheduler #(
  parameter int NUM_ENG    = 4,
  parameter int CHUNK_LOG2 = 20,
  localparam int CW        = 56 - CHUNK_LOG2,
  localparam int PW        = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_ENG-1:0]    eng_busy,
  input  logic [NUM_ENG-1:0]    eng_found,
  input  logic [56*NUM_ENG-1:0] eng_key,
`ifdef CRACK_SCHED_LIMIT_EN
  input  logic [CW:0]           chunk_limit,
`endif
  output logic [NUM_ENG-1:0]    eng_go,
  output logic [55:0]           eng_base,
  output logic                  eng_kill,
  output logic [55:0]           key_out,
  output logic                  found,
  output logic                  done,
  output logic                  busy,
  output logic [CW:0]           chunks_issued
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DISPATCH = 3'd1;
  localparam logic [2:0] S_DRAIN    = 3'd2;
  localparam logic [2:0] S_HIT      = 3'd3;
  localparam logic [2:0] S_END      = 3'd4;

  // One past the last chunk index: the whole keyspace.
  localparam logic [CW:0] FULL_COUNT = {1'b1, {CW{1'b0}}};

  logic [2:0]         state_q, state_d;
  logic [NUM_ENG-1:0] eng_go_q, eng_go_d;
  logic [55:0]        eng_base_q, eng_base_d;
  logic               eng_kill_q, eng_kill_d;
  logic [55:0]        key_q, key_d;
  logic               found_q, found_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [CW:0]        cnt_q, cnt_d;
  logic [PW-1:0]      rr_q, rr_d;

  logic               grant_vld;
  logic [PW-1:0]      grant_idx;
  logic [PW-1:0]      rr_next;
  logic               hit_vld;
  logic [55:0]        hit_key;
  logic [CW:0]        limit_eff;

`ifdef CRACK_SCHED_LIMIT_EN
  logic [CW:0]        limit_q, limit_d;

  // A zero (or oversized) limit means the full keyspace.
  assign limit_eff = ((limit_q == '0) || (limit_q > FULL_COUNT)) ? FULL_COUNT : limit_q;
`else
  assign limit_eff = FULL_COUNT;
`endif

  // Pick the first idle engine at or after the round-robin pointer; an engine
  // launched last cycle has not raised eng_busy yet, so it is skipped too.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_p;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_p     = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_ENG) begin
        idx = idx - NUM_ENG;
      end
      idx_p = PW'(idx);
      if (!grant_vld && !eng_busy[idx_p] && !eng_go_q[idx_p]) begin
        grant_vld = 1'b1;
        grant_idx = idx_p;
      end
    end
    if (grant_idx == PW'(NUM_ENG - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = grant_idx + PW'(1);
    end
  end

  // Lowest-numbered busy engine reporting a match wins the key latch.
  always_comb begin
    hit_vld = 1'b0;
    hit_key = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (eng_found[i] && eng_busy[i]) begin
        hit_vld = 1'b1;
        hit_key = eng_key[56*i +: 56];
      end
    end
  end

  // Next-state and registered-output logic: abort > hit > launch.
  always_comb begin
    state_d    = state_q;
    eng_go_d   = '0;
    eng_base_d = eng_base_q;
    eng_kill_d = 1'b0;
    key_d      = key_q;
    found_d    = found_q;
    done_d     = done_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
`ifdef CRACK_SCHED_LIMIT_EN
    limit_d    = limit_q;
`endif
    if (state_q == S_IDLE) begin
      if (start) begin
        found_d = 1'b0;
        done_d  = 1'b0;
        key_d   = '0;
        cnt_d   = '0;
`ifdef CRACK_SCHED_LIMIT_EN
        limit_d = chunk_limit;
`endif
        state_d = S_DISPATCH;
      end
    end else if (abort) begin
      eng_kill_d = 1'b1;
      found_d    = 1'b0;
      done_d     = 1'b0;
      state_d    = S_IDLE;
    end else begin
      case (state_q)
        S_DISPATCH, S_DRAIN: begin
          if (hit_vld) begin
            key_d      = hit_key;
            found_d    = 1'b1;
            done_d     = 1'b1;
            eng_kill_d = 1'b1;
            state_d    = S_HIT;
          end else if (state_q == S_DISPATCH) begin
            if (grant_vld) begin
              eng_go_d   = NUM_ENG'(1) << grant_idx;
              eng_base_d = {cnt_q[CW-1:0], {CHUNK_LOG2{1'b0}}};
              cnt_d      = cnt_q + (CW+1)'(1);
              rr_d       = rr_next;
              if (cnt_d == limit_eff) begin
                state_d = S_DRAIN;
              end
            end
          end else begin
            // Wait for every lane, including one launched last cycle, to go quiet.
            if ((eng_busy == '0) && (eng_go_q == '0)) begin
              done_d  = 1'b1;
              state_d = S_END;
            end
          end
        end
        S_HIT, S_END: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      eng_go_q   <= '0;
      eng_base_q <= '0;
      eng_kill_q <= 1'b0;
      key_q      <= '0;
      found_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      rr_q       <= '0;
`ifdef CRACK_SCHED_LIMIT_EN
      limit_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      eng_go_q   <= eng_go_d;
      eng_base_q <= eng_base_d;
      eng_kill_q <= eng_kill_d;
      key_q      <= key_d;
      found_q    <= found_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
`ifdef CRACK_SCHED_LIMIT_EN
      limit_q    <= limit_d;
`endif
    end
  end

  assign eng_go        = eng_go_q;
  assign eng_base      = eng_base_q;
  assign eng_kill      = eng_kill_q;
  assign key_out       = key_q;
  assign found         = found_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign chunks_issued = cnt_q;

endmodule

// File: tb/tb_crack_scheduler.sv
// tb/tb_crack_scheduler.sv - randomized bench for crack_scheduler against a behavioural search model
module tb_crack_scheduler;
  localparam int     N     = 2;
  localparam int     CL    = 52;
  localparam int     CW    = 56 - CL;
  localparam longint TOTAL = longint'(1) << CW;
  localparam longint CHUNK = longint'(1) << CL;
  localparam int ST_IDLE = 0, ST_DISP = 1, ST_DRAIN = 2, ST_HIT = 3, ST_END = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            abort;
  logic [N-1:0]    eng_busy;
  logic [N-1:0]    eng_found;
  logic [56*N-1:0] eng_key;
  logic [N-1:0]    eng_go;
  logic [55:0]     eng_base;
  logic            eng_kill;
  logic [55:0]     key_out;
  logic            found;
  logic            done;
  logic            busy;
  logic [CW:0]     chunks_issued;
`ifdef CRACK_SCHED_LIMIT_EN
  logic [CW:0]     chunk_limit;
`endif

  crack_scheduler #(.NUM_ENG(N), .CHUNK_LOG2(CL)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .eng_busy      (eng_busy),
    .eng_found     (eng_found),
    .eng_key       (eng_key),
`ifdef CRACK_SCHED_LIMIT_EN
    .chunk_limit   (chunk_limit),
`endif
    .eng_go        (eng_go),
    .eng_base      (eng_base),
    .eng_kill      (eng_kill),
    .key_out       (key_out),
    .found         (found),
    .done          (done),
    .busy          (busy),
    .chunks_issued (chunks_issued)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Search model: what the scheduler should show after each edge.
  int           m_st;
  logic [N-1:0] m_go;
  logic [55:0]  m_base;
  logic         m_kill;
  logic [55:0]  m_key;
  logic         m_found, m_done, m_busy;
  longint       m_cnt, m_lim;
  int           m_rr;

  // Engine lane models and stimulus policy.
  int           age[N], dur[N], hit_at[N], launches[N];
  logic [55:0]  ekey[N];
  int           dur_min, dur_max, hit_pct, abort_pct, start_noise;
  int           force_eng, force_launch;
  logic [55:0]  force_key;
  bit           sim_mode, abort_on_hit;
  logic [55:0]  key_a, key_b;
  int           g_gos, g_kills;

  function automatic logic [55:0] rand56();
    return 56'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    m_st = ST_IDLE; m_go = '0; m_base = '0; m_kill = 1'b0; m_key = '0;
    m_found = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_cnt = 0; m_rr = 0; m_lim = TOTAL;
  endtask

  task automatic engines_reset();
    eng_busy = '0; eng_found = '0; eng_key = '0;
    for (int e = 0; e < N; e++) begin
      age[e] = 0; dur[e] = 0; hit_at[e] = 0; launches[e] = 0; ekey[e] = '0;
    end
  endtask

  // Advance the model over one clock edge using the inputs now applied.
  task automatic model_step();
    logic [N-1:0] prev_go;
    int hit, g, i;
    prev_go = m_go;
    hit = -1;
    g = -1;
    m_go = '0;
    m_kill = 1'b0;
    for (int k = 0; k < N; k++) if (hit < 0 && eng_found[k] && eng_busy[k]) hit = k;
    if (m_st == ST_IDLE) begin
      if (start) begin
        m_found = 1'b0; m_done = 1'b0; m_key = '0; m_cnt = 0;
`ifdef CRACK_SCHED_LIMIT_EN
        m_lim = (chunk_limit == 0 || longint'(chunk_limit) > TOTAL) ? TOTAL : longint'(chunk_limit);
`else
        m_lim = TOTAL;
`endif
        m_st = ST_DISP;
      end
    end else if (abort) begin
      m_kill = 1'b1; m_found = 1'b0; m_done = 1'b0; m_st = ST_IDLE;
    end else if ((m_st == ST_DISP || m_st == ST_DRAIN) && hit >= 0) begin
      m_key = eng_key[56*hit +: 56]; m_found = 1'b1; m_done = 1'b1; m_kill = 1'b1; m_st = ST_HIT;
    end else if (m_st == ST_DISP) begin
      for (int k = 0; k < N; k++) begin
        i = (m_rr + k) % N;
        if (g < 0 && !eng_busy[i] && !prev_go[i]) g = i;
      end
      if (g >= 0) begin
        m_go[g] = 1'b1;
        m_base = 56'(m_cnt * CHUNK);
        m_cnt++;
        m_rr = (g + 1) % N;
        if (m_cnt == m_lim) m_st = ST_DRAIN;
      end
    end else if (m_st == ST_DRAIN) begin
      if (eng_busy == '0 && prev_go == '0) begin
        m_done = 1'b1; m_st = ST_END;
      end
    end else begin
      m_st = ST_IDLE;
    end
    m_busy = (m_st != ST_IDLE);
  endtask

  // Lanes react to the launch/kill pulses visible before the edge just taken.
  task automatic engines_update(input logic [N-1:0] pgo, input logic pkill);
    for (int e = 0; e < N; e++) begin
      if (pkill) begin
        eng_busy[e] = 1'b0; eng_found[e] = 1'b0; hit_at[e] = 0;
      end else if (pgo[e]) begin
        eng_busy[e] = 1'b1; eng_found[e] = 1'b0; launches[e]++; age[e] = 1;
        dur[e] = $urandom_range(dur_max, dur_min); hit_at[e] = 0;
        if (force_eng == e && launches[e] == force_launch) begin
          hit_at[e] = (dur[e] > 1) ? 2 : 1; ekey[e] = force_key;
        end else if ($urandom_range(99, 0) < hit_pct) begin
          hit_at[e] = $urandom_range(dur[e], 1); ekey[e] = rand56();
        end
      end else if (eng_busy[e] && !eng_found[e]) begin
        age[e]++;
        if (age[e] > dur[e]) eng_busy[e] = 1'b0;
      end
      if (eng_busy[e] && !eng_found[e] && hit_at[e] != 0 && age[e] == hit_at[e]) begin
        eng_found[e] = 1'b1;
        eng_key[56*e +: 56] = ekey[e];
      end
    end
    if (sim_mode && eng_busy == '1 && eng_found == '0) begin
      eng_found = '1;
      eng_key[55:0] = key_a;
      eng_key[111:56] = key_b;
      sim_mode = 1'b0;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] pgo;
    logic pkill;
    pgo = m_go;
    pkill = m_kill;
    model_step();
    @(posedge clk);
    #1;
    check("eng_go", 64'(eng_go), 64'(m_go));
    check("eng_kill", 64'(eng_kill), 64'(m_kill));
    check("found", 64'(found), 64'(m_found));
    check("done", 64'(done), 64'(m_done));
    check("busy", 64'(busy), 64'(m_busy));
    check("chunks_issued", 64'(chunks_issued), 64'(m_cnt));
    check("key_out", 64'(key_out), 64'(m_key));
    if (m_go != '0) check("eng_base", 64'(eng_base), 64'(m_base));
    if (eng_go != '0) g_gos++;
    if (eng_kill) g_kills++;
    engines_update(pgo, pkill);
    start = 1'b0;
    abort = 1'b0;
    if (m_busy && $urandom_range(99, 0) < start_noise) start = 1'b1;
    if ($urandom_range(99, 0) < abort_pct) abort = 1'b1;
    if (abort_on_hit && (eng_found & eng_busy) != '0 && (m_st == ST_DISP || m_st == ST_DRAIN))
      abort = 1'b1;
  endtask

  task automatic finish_search(input int maxc);
    int n;
    n = 0;
    while (m_busy && n < maxc) begin
      cycle();
      n++;
    end
    check("search_end_busy", 64'(busy), 64'(0));
    repeat (3) cycle();
  endtask

  task automatic run_search(input int maxc);
    g_gos = 0;
    g_kills = 0;
    for (int e = 0; e < N; e++) launches[e] = 0;
    start = 1'b1;
    cycle();
    finish_search(maxc);
  endtask

  task automatic policy_default();
    dur_min = 3; dur_max = 3; hit_pct = 0; abort_pct = 0; start_noise = 0;
    force_eng = -1; force_launch = 0; force_key = '0; sim_mode = 1'b0; abort_on_hit = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
`ifdef CRACK_SCHED_LIMIT_EN
    chunk_limit = '0;
`endif
    policy_default();
    model_reset();
    engines_reset();
    g_gos = 0; g_kills = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_eng_go", 64'(eng_go), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_chunks", 64'(chunks_issued), 64'(0));
    @(negedge clk) reset = 1'b1;
    repeat (3) cycle();

    // Exhaustion: 16 chunks, 3-cycle lanes, no hits.
    run_search(400);
    check("exh_gos", 64'(g_gos), 64'(16));
    check("exh_chunks", 64'(chunks_issued), 64'(16));
    check("exh_done", 64'(done), 64'(1));
    check("exh_found", 64'(found), 64'(0));

    // Engine 1 hits on its third chunk.
    policy_default();
    dur_min = 2; dur_max = 4;
    force_eng = 1; force_launch = 3; force_key = 56'h00_1234_5678_9ABC;
    run_search(400);
    check("hit_key", 64'(key_out), 64'h0012_3456_789A_BC);
    check("hit_found", 64'(found), 64'(1));
    check("hit_done", 64'(done), 64'(1));
    check("hit_kill_pulses", 64'(g_kills), 64'(1));

    // Two engines report in the same cycle: the lower index wins.
    policy_default();
    dur_min = 6; dur_max = 6;
    key_a = rand56(); key_b = ~key_a;
    sim_mode = 1'b1;
    run_search(400);
    check("sim_key", 64'(key_out), 64'(key_a));
    check("sim_found", 64'(found), 64'(1));

    // Abort arrives with a hit: abort wins, then a restart clears the count.
    policy_default();
    hit_pct = 100; abort_on_hit = 1'b1;
    run_search(400);
    check("abort_found", 64'(found), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_kill_pulses", 64'(g_kills), 64'(1));
    policy_default();
    start = 1'b1;
    cycle();
    check("restart_chunks", 64'(chunks_issued), 64'(0));
    finish_search(400);

    // Asynchronous reset in the middle of dispatch.
    policy_default();
    start = 1'b1;
    cycle();
    for (int n = 0; n < 100 && !(m_st == ST_DISP && m_cnt >= 3); n++) cycle();
    reset = 1'b0;
    #2;
    check("mid_rst_eng_go", 64'(eng_go), 64'(0));
    check("mid_rst_kill", 64'(eng_kill), 64'(0));
    check("mid_rst_key", 64'(key_out), 64'(0));
    check("mid_rst_found", 64'(found), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_chunks", 64'(chunks_issued), 64'(0));
    model_reset();
    engines_reset();
    start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    g_gos = 0;
    repeat (5) cycle();
    check("post_rst_gos", 64'(g_gos), 64'(0));

`ifdef CRACK_SCHED_LIMIT_EN
    policy_default();
    chunk_limit = 5;
    run_search(400);
    check("lim_gos", 64'(g_gos), 64'(5));
    check("lim_chunks", 64'(chunks_issued), 64'(5));
    check("lim_done", 64'(done), 64'(1));
    check("lim_found", 64'(found), 64'(0));
`endif

    // Randomized searches with noise on start/abort and sparse hits.
    for (int s = 0; s < 24; s++) begin
      policy_default();
      dur_min = 1;
      dur_max = $urandom_range(5, 1);
      hit_pct = $urandom_range(8, 0);
      abort_pct = (s % 4 == 0) ? 2 : 0;
      start_noise = 10;
`ifdef CRACK_SCHED_LIMIT_EN
      chunk_limit = (CW+1)'($urandom_range(17, 0));
`endif
      run_search(2000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crack_scheduler.md
Name: crack_scheduler

Overview:
- Top-level sequencer for a multi-engine DES key search.
- The 56-bit keyspace is split into aligned chunks of 2^CHUNK_LOG2 keys. Chunks are dispatched round-robin to NUM_ENG cracking engines (each a counter + parity + DES + compare lane).
- The first reported hit is latched, and all engines are then killed.
- Replaces the single-lane control FSM when the design scales past one DES core.

Parameters:
- NUM_ENG, 4, number of cracking engines (1..16).
- CHUNK_LOG2, 20, log2 of keys per chunk (1..55). Chunk index width CW = 56-CHUNK_LOG2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a search; sampled in IDLE only.
- abort  input  1  cancel the search in progress.
- eng_busy  input  NUM_ENG  engine i is searching its chunk.
- eng_found  input  NUM_ENG  engine i found a matching key; level, held while busy.
- eng_key  input  56*NUM_ENG  found key of engine i at bits [56*i+55:56*i].
- eng_go  output  NUM_ENG  one-cycle launch pulse; at most one bit set per cycle.
- eng_base  output  56  chunk base key (index << CHUNK_LOG2); valid while eng_go != 0.
- eng_kill  output  1  one-cycle pulse that stops all engines.
- key_out  output  56  latched found key.
- found  output  1  key found.
- done  output  1  search finished (found or exhausted).
- busy  output  1  FSM not in IDLE.
- chunks_issued  output  CW+1  number of chunks dispatched so far.

Behaviour:
- Reset (async, reset=0):
  - State IDLE.
  - Outputs eng_go, eng_kill, key_out, found, done, busy, chunks_issued are all 0.
  - Round-robin pointer is 0. Next chunk index is 0.
- States: IDLE, DISPATCH, DRAIN, HIT, END. All outputs are registered.
- IDLE:
  - On start=1: clear found, done, key_out, chunks_issued and the next index; go to DISPATCH next cycle.
  - done/found/key_out hold their values until the next start.
- DISPATCH:
  - Each cycle, an engine is eligible when eng_busy[i]=0 and it was not launched in the previous cycle. Engines must raise eng_busy the cycle after eng_go.
  - The eligible engine nearest the RR pointer (inclusive, wrapping) receives eng_go and eng_base.
  - After a launch, the pointer moves to the granted index + 1, and chunks_issued and the next index increment.
  - When chunks_issued reaches 2^CW, go to DRAIN. No wrap-around; the last index issued is 2^CW-1.
- DRAIN:
  - No launches.
  - When all eng_busy=0 (and the previous-cycle launch mask is clear), go to END.
- Hit detection (DISPATCH or DRAIN): when any eng_found[i]=1 and eng_busy[i]=1:
  - Latch eng_key slice of the lowest such i into key_out.
  - Set found=1 and done=1, pulse eng_kill for one cycle, go to HIT.
  - A hit takes priority over a launch in the same cycle; that cycle's eng_go is suppressed.
- HIT / END:
  - END sets done=1 with found=0.
  - Both states return to IDLE the next cycle. busy=0 in IDLE.
- abort=1 in any non-IDLE state:
  - Pulse eng_kill, suppress eng_go, go to IDLE.
  - done=0 and found=0; chunks_issued holds.
  - abort outranks a simultaneous hit.
- start while busy=1 is ignored. abort in IDLE is ignored.

Optional Feature:
- Macro: CRACK_SCHED_LIMIT_EN.
- Defined:
  - Adds input chunk_limit [CW:0], sampled on start.
  - DISPATCH moves to DRAIN once chunks_issued == chunk_limit.
  - chunk_limit=0 means the full 2^CW chunks.
- Undefined: the port is absent and the full keyspace is always searched.

Test Plan:
- Reset: assert reset=0 mid-DISPATCH -> all outputs 0 immediately, state IDLE, no eng_go after release.
- Exhaustion with NUM_ENG=2, CHUNK_LOG2=52 (16 chunks); engines model 3 busy cycles, no hits -> eng_go alternates 01,10,...; eng_base steps by 2^52; chunks_issued=16; then done=1, found=0.
- Hit: engine 1 raises eng_found with key 56'h00_1234_5678_9ABC on its 3rd chunk -> key_out=that value, found=1, done=1, eng_kill pulse exactly 1 cycle, no further eng_go.
- Simultaneous: eng_found on engines 0 and 1 in the same cycle, keys A and B -> key_out=A; a launch pending that cycle is suppressed.
- Abort vs hit: abort=1 in the same cycle as eng_found -> found=0, done=0, eng_kill pulse, IDLE; a new start clears chunks_issued to 0.
- LIMIT_EN: chunk_limit=5 -> exactly 5 eng_go pulses, then DRAIN, then done=1 with chunks_issued=5.
